bus_register: RTL and testbench
===============================

// Module: bus_register
// PURPOSE
//   Single WIDTH-bit storage register with a tri-state output, for use on a shared data bus.
//   Active-low chip select (sel) and active-low write enable (we) follow SRAM/bus-slave style.
//   The register captures inData on a selected write.
//   It drives outData only on a selected read; otherwise outData floats so other slaves can drive the bus.
// PARAMETERS
//   WIDTH  16  data width in bits of inData, outData and the storage register (WIDTH >= 1)
// PORTS
//   clk      in   1      clock; all state changes except reset occur on the rising edge
//   rstn     in   1      reset, asynchronous, active-low
//   we       in   1      write enable, active-low (0 = write, 1 = read)
//   sel      in   1      chip select, active-low (0 = selected, 1 = deselected)
//   inData   in   WIDTH  write data
//   outData  out  WIDTH  tri-state read data
// BEHAVIOUR
//   - One clock domain (clk).
//   - Reset is asynchronous and active-low:
//     - rstn=0 immediately clears the storage register to {WIDTH{1'b0}}, regardless of clk, we or sel.
//     - Reset dominates all other inputs for as long as rstn=0.
//     - The register holds 0 after rstn is released until the first write.
//   - Write: at posedge clk with rstn=1, sel=0 and we=0, the register loads inData.
//     - The new value is visible on a subsequent read from the next cycle (1-cycle latency).
//   - Hold: at any other posedge (sel=1, or we=1) the register keeps its value.
//     - inData is ignored in this case.
//   - Output enable is combinational and does not wait for a clock edge:
//     - sel=0 and we=1: outData = stored value.
//     - Any other combination: outData = {WIDTH{1'bz}}. This covers sel=1, and sel=0 with we=0
//       (no bus contention while a master drives the write data).
//   - During reset the output rule is unchanged:
//     - sel=0, we=1 with rstn=0 drives all-zero.
//     - All other select/enable combinations give high-Z.
//   - Changing we or sel mid-cycle changes only the output enable; storage is sampled at posedge only.
//   - Reset asserted mid-write: the clear wins and no write occurs while rstn=0.
//   - All-ones and all-zeros inData are stored and read back exactly; there is no width conversion.
// TESTING
//   Use a clk period of 2 ns and WIDTH=16.
//   1. Reset: rstn=0, we=1, sel=1, inData=16'hAAAA for 5 ns -> outData=16'hzzzz.
//      Then set sel=0 with rstn still 0 -> outData=16'h0000.
//   2. Write: rstn=1, sel=0, we=0, inData=16'hAAAA for 5 ns -> outData=16'hzzzz throughout the write.
//   3. Read: keep sel=0, set we=1 -> outData=16'hAAAA with no clock edge needed; it holds for 5 ns.
//   4. Deselect: set sel=1 (we=1) -> outData=16'hzzzz.
//      Changing inData to 16'h5555 with sel=1, we=0 over several edges, then reading, still gives 16'hAAAA.
//   5. Async reset mid-read: with 16'hAAAA stored, sel=0, we=1, pulse rstn=0 between clock edges.
//      -> outData=16'h0000 immediately, and it stays 0 after rstn is released.
//   6. Back-to-back writes of 16'hFFFF then 16'h0001 on consecutive edges, then read -> 16'h0001.
//      Read during the write (we=1 at the capture edge) -> no capture.

Source files
------------

// File: rtl/bus_register.sv
// Single storage register with a tri-state read port for a shared data bus.
// Active-low select and write enable; reset is asynchronous and active-low.
`timescale 1ns/1ps
module bus_register #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             we,
   input  logic             sel,
   input  logic [WIDTH-1:0] inData,
   output logic [WIDTH-1:0] outData
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             wr_en;
   logic             rd_en;

   always_comb begin
      wr_en  = ~sel & ~we;
      rd_en  = ~sel & we;
      data_d = data_q;
      if (wr_en) begin
         data_d = inData;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // Enable is combinational; the bus floats during writes to avoid contention with the master.
   assign outData = rd_en ? data_q : 'z;

endmodule

// File: tb/tb_bus_register.sv
// Scoreboard bench for bus_register: expectations are queued as stimulus is applied
// and popped when the bus is sampled half a clock phase later.
`timescale 1ns/1ps
module tb_bus_register;

   localparam int          WIDTH = 16;
   // Value a second bus slave drives whenever the DUT is expected to float.
   localparam logic [15:0] OTHER = 16'h0000;

   logic             clk;
   logic             rstn;
   logic             we;
   logic             sel;
   logic [WIDTH-1:0] inData;
   logic             oth_en;
   tri   [WIDTH-1:0] bus;

   int unsigned checks;
   int unsigned errors;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];

   assign bus = oth_en ? OTHER : 'z;

   bus_register #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .we      (we),
      .sel     (sel),
      .inData  (inData),
      .outData (bus)
   );

   initial clk = 1'b0;
   always #1 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      exp_t e;
      if (sb.size() == 0) begin
         check_eq("sb_empty", bus, 16'hxxxx);
      end else begin
         e = sb.pop_front();
         check_eq(e.tag, bus, e.val);
      end
   endtask

   // flt=1: DUT must release the bus, so the other slave's value must appear unaltered.
   task automatic expect_out(input string tag, input bit flt, input logic [15:0] v);
      exp_t e;
      e.tag  = tag;
      e.val  = flt ? OTHER : v;
      oth_en = flt;
      sb.push_back(e);
      #0.5;
      sample();
      oth_en = 1'b0;
   endtask

   task automatic set_in(input logic r, input logic w, input logic s, input logic [15:0] d);
      rstn   = r;
      we     = w;
      sel    = s;
      inData = d;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      oth_en = 1'b0;

      // Reset with deselect: bus floats
      set_in(1'b0, 1'b1, 1'b1, 16'hAAAA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_out("rst_float", 1'b1, 16'h0000);
      end
      // Select during reset drives zero
      @(negedge clk);
      sel = 1'b0;
      expect_out("rst_read", 1'b0, 16'h0000);
      // Write attempt while in reset must be ignored
      @(negedge clk);
      we = 1'b0;
      expect_out("rst_wr_float", 1'b1, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      we = 1'b1;
      expect_out("rst_wr_ignored", 1'b0, 16'h0000);

      // Write AAAA; bus floats while writing
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 16'hAAAA);
      expect_out("wr_float0", 1'b1, 16'h0000);
      @(negedge clk);
      expect_out("wr_float1", 1'b1, 16'h0000);
      @(negedge clk);
      expect_out("wr_float2", 1'b1, 16'h0000);

      // Read without waiting for an edge, then hold
      we = 1'b1;
      #0.2;
      expect_out("rd_comb", 1'b0, 16'hAAAA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_out("rd_hold", 1'b0, 16'hAAAA);
      end

      // Deselect floats; writes while deselected are ignored
      @(negedge clk);
      sel = 1'b1;
      expect_out("desel_float", 1'b1, 16'h0000);
      inData = 16'h5555;
      we     = 1'b0;
      repeat (3) @(negedge clk);
      expect_out("desel_wr_float", 1'b1, 16'h0000);
      set_in(1'b1, 1'b1, 1'b0, 16'h5555);
      expect_out("desel_kept", 1'b0, 16'hAAAA);

      // Async reset pulse between edges during a read
      @(negedge clk);
      #0.1;
      rstn = 1'b0;
      expect_out("async_rst", 1'b0, 16'h0000);
      #0.2;
      rstn = 1'b1;
      @(negedge clk);
      expect_out("after_rst", 1'b0, 16'h0000);

      // Back-to-back writes, last one wins
      set_in(1'b1, 1'b0, 1'b0, 16'hFFFF);
      @(negedge clk);
      inData = 16'h0001;
      @(negedge clk);
      we = 1'b1;
      expect_out("b2b_last", 1'b0, 16'h0001);

      // Read at capture edges: no capture
      inData = 16'h1234;
      repeat (2) @(negedge clk);
      expect_out("rd_no_cap", 1'b0, 16'h0001);
      // Mid-cycle write-enable glitch that ends before the edge: no capture
      @(negedge clk);
      we = 1'b0;
      #0.3;
      we = 1'b1;
      @(negedge clk);
      expect_out("glitch_no_cap", 1'b0, 16'h0001);

      // All-ones and all-zeros round trip
      set_in(1'b1, 1'b0, 1'b0, 16'hFFFF);
      @(negedge clk);
      we = 1'b1;
      expect_out("all_ones", 1'b0, 16'hFFFF);
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      we = 1'b1;
      expect_out("all_zeros", 1'b0, 16'h0000);

      // Reset asserted across a write edge: clear wins
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 16'hC3C3);
      @(negedge clk);
      we = 1'b1;
      expect_out("pre_rst_val", 1'b0, 16'hC3C3);
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 16'hBEEF);
      @(negedge clk);
      rstn = 1'b1;
      we   = 1'b1;
      expect_out("rst_mid_wr", 1'b0, 16'h0000);

      if (sb.size() != 0) begin
         check_eq("sb_leftover", 16'(sb.size()), 16'h0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
